// File: rtl/datapath_if.sv
// Control/data bundle between the sequencing controller and the datapath.
// Latency: none. The interface holds wires only.
// Backpressure: none. The controller sequences every select and load enable.
//
// Signals:
//   datapath_in  immediate / external data
//   writenum     register file write index
//   readnum      register file read index
//   write        register file write enable
//   loada        A load enable
//   loadb        B load enable
//   loadc        C load enable
//   loads        Z load enable
//   asel         ALU A operand select
//   bsel         ALU B operand select
//   vsel         write-back data select
//   shift        shifter operation
//   ALUop        ALU operation
//   datapath_out register C (returned to the controller)
//   Z_out        Z flag (returned to the controller)
interface datapath_if #(
    parameter int data_width = 16
);
    logic [data_width-1:0] datapath_in;
    logic [2:0]            writenum;
    logic [2:0]            readnum;
    logic                  write;
    logic                  loada;
    logic                  loadb;
    logic                  loadc;
    logic                  loads;
    logic                  asel;
    logic                  bsel;
    logic                  vsel;
    logic [2:0]            shift;
    logic [2:0]            ALUop;
    logic [data_width-1:0] datapath_out;
    logic                  Z_out;

    modport master (
        output datapath_in, writenum, readnum, write,
        output loada, loadb, loadc, loads,
        output asel, bsel, vsel, shift, ALUop,
        input  datapath_out, Z_out
    );

    modport slave (
        input  datapath_in, writenum, readnum, write,
        input  loada, loadb, loadc, loads,
        input  asel, bsel, vsel, shift, ALUop,
        output datapath_out, Z_out
    );
endinterface

// File: rtl/datapath.sv
// Datapath for a 16-bit RISC core. It contains an 8x register file, A and B operand registers, a shifter on B, a 4-op ALU, result register C and zero flag Z.
// Latency: one edge per stage. Stages are read->A/B, A/B->C/Z and C->register file, so a full op takes 4 cycles.
// Backpressure: none. Every select and enable comes from the controller, and there are no stalls.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high. Clears R0..R7, A, B, C and Z.
//   dp     datapath_if.slave. Carries the controls and datapath_in in, and datapath_out and Z_out back.
module datapath #(
    parameter int data_width = 16
) (
    input  logic      clk,
    input  logic      reset,
    datapath_if.slave dp
);
    logic [data_width-1:0] regs [8];
    logic [data_width-1:0] read_dat;
    logic [data_width-1:0] wb_dat;
    logic [data_width-1:0] a_q;
    logic [data_width-1:0] b_q;
    logic [data_width-1:0] c_q;
    logic                  z_q;
    logic [data_width-1:0] b_shift;
    logic [data_width-1:0] ain;
    logic [data_width-1:0] bin;
    logic [data_width-1:0] alu_res;

    // Reads are combinational and have no write bypass.
    // A read of the index being written returns the pre-edge value.
    assign read_dat = regs[dp.readnum];

    // The write-back value is C before this edge, because c_q updates on the same edge.
    assign wb_dat = dp.vsel ? dp.datapath_in : c_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (dp.write) begin
            regs[dp.writenum] <= wb_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (dp.loada) a_q <= read_dat;
            if (dp.loadb) b_q <= read_dat;
        end
    end

    always_comb begin
        b_shift = b_q;
        case (dp.shift)
            3'b001:  b_shift = {b_q[data_width-2:0], 1'b0};
            3'b010:  b_shift = {1'b0, b_q[data_width-1:1]};
            3'b011:  b_shift = {b_q[data_width-1], b_q[data_width-1:1]};
            default: b_shift = b_q;
        endcase
    end

    // The immediate operand is the low 5 bits of datapath_in, zero-extended.
    assign ain = dp.asel ? '0 : a_q;
    assign bin = dp.bsel ? {{(data_width-5){1'b0}}, dp.datapath_in[4:0]} : b_shift;

    always_comb begin
        alu_res = '0;
        case (dp.ALUop)
            3'b000:  alu_res = ain + bin;
            3'b001:  alu_res = ain - bin;
            3'b010:  alu_res = ain & bin;
            3'b011:  alu_res = ~bin;
            default: alu_res = '0;
        endcase
    end

    // Z is taken from this cycle's ALU result, not from C.
    // This lets loads alone update the flag without touching C.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= '0;
            z_q <= 1'b0;
        end else begin
            if (dp.loadc) c_q <= alu_res;
            if (dp.loads) z_q <= (alu_res == '0);
        end
    end

    assign dp.datapath_out = c_q;
    assign dp.Z_out        = z_q;
endmodule

// File: tb/tb_datapath.sv
// Testbench for datapath. It runs directed steps, then random control, against an arithmetic reference model.
// Latency: one clock per applied vector. Outputs are sampled 1 ns after the rising edge.
// Backpressure: none.
module tb_datapath;
    localparam int DW  = 16;
    localparam int MOD = 1 << DW;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    // Reference state, held as plain integers.
    int m_r [8];
    int m_a;
    int m_b;
    int m_c;
    int m_z;

    datapath_if #(.data_width(DW)) dp ();

    datapath #(.data_width(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    function automatic int shift_ref(int b, int op);
        case (op)
            1:       return (b * 2) % MOD;
            2:       return b / 2;
            3:       return b / 2 + ((b >= MOD / 2) ? MOD / 2 : 0);
            default: return b;
        endcase
    endfunction

    function automatic int alu_ref(int a, int b, int op);
        case (op)
            0:       return (a + b) % MOD;
            1:       return (a - b + MOD) % MOD;
            2:       return a & b;
            3:       return (MOD - 1) - b;
            default: return 0;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, int exp);
        vectors++;
        assert (got === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Update the model from the inputs now on the bus, clock once, then compare the outputs.
    task automatic apply();
        int rd, ain, bin, res, wb;
        rd  = m_r[dp.readnum];
        ain = dp.asel ? 0 : m_a;
        bin = dp.bsel ? int'(dp.datapath_in) % 32 : shift_ref(m_b, int'(dp.shift));
        res = alu_ref(ain, bin, int'(dp.ALUop));
        wb  = dp.vsel ? int'(dp.datapath_in) : m_c;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_r[i] = 0;
            m_a = 0; m_b = 0; m_c = 0; m_z = 0;
        end else begin
            if (dp.write) m_r[dp.writenum] = wb;
            if (dp.loada) m_a = rd;
            if (dp.loadb) m_b = rd;
            if (dp.loadc) m_c = res;
            if (dp.loads) m_z = (res == 0) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        check("model_c", 32'(dp.datapath_out), m_c);
        check("model_z", 32'(dp.Z_out), m_z);
    endtask

    task automatic idle();
        reset = 1'b0;
        dp.datapath_in = '0; dp.writenum = '0; dp.readnum = '0;
        dp.write = 1'b0; dp.loada = 1'b0; dp.loadb = 1'b0;
        dp.loadc = 1'b0; dp.loads = 1'b0; dp.asel = 1'b0;
        dp.bsel = 1'b0; dp.vsel = 1'b0; dp.shift = '0; dp.ALUop = '0;
    endtask

    task automatic wr_imm(int idx, int val);
        idle();
        dp.write = 1'b1; dp.vsel = 1'b1;
        dp.writenum = 3'(idx); dp.datapath_in = DW'(val);
        apply();
    endtask

    task automatic ld_a(int idx);
        idle(); dp.readnum = 3'(idx); dp.loada = 1'b1; apply();
    endtask

    task automatic ld_b(int idx);
        idle(); dp.readnum = 3'(idx); dp.loadb = 1'b1; apply();
    endtask

    task automatic op(bit as, bit bs, int sh, int aop, int din, bit lc, bit ls);
        idle();
        dp.asel = as; dp.bsel = bs; dp.shift = 3'(sh); dp.ALUop = 3'(aop);
        dp.datapath_in = DW'(din); dp.loadc = lc; dp.loads = ls;
        apply();
    endtask

    // Route R[idx] to C through A and an add with a zero immediate, then compare C with a constant.
    task automatic read_reg(int idx, int exp, string tag);
        ld_a(idx);
        op(1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0);
        check(tag, 32'(dp.datapath_out), exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_a = 0; m_b = 0; m_c = 0; m_z = 0;
        idle();
        @(negedge clk);

        // Reset with every enable high.
        // The first reset establishes known state. The second lands on non-zero contents.
        reset = 1'b1; apply();
        for (int i = 0; i < 8; i++) wr_imm(i, int'($urandom_range(1, MOD - 1)));
        ld_a(3); ld_b(5);
        op(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
        idle();
        reset = 1'b1; dp.write = 1'b1; dp.loada = 1'b1; dp.loadb = 1'b1;
        dp.loadc = 1'b1; dp.loads = 1'b1; dp.vsel = 1'b1; dp.datapath_in = 16'hBEEF;
        apply();
        check("reset_out", 32'(dp.datapath_out), 0);
        check("reset_z", 32'(dp.Z_out), 0);
        for (int i = 0; i < 8; i++) read_reg(i, 0, "reset_reg");

        // Add with a left shift on B, then write the result back from C.
        wr_imm(0, 7); wr_imm(1, 2);
        ld_b(0); ld_a(1);
        op(1'b0, 1'b0, 1, 0, 0, 1'b1, 1'b1);
        check("add_shift_out", 32'(dp.datapath_out), 16);
        check("add_shift_z", 32'(dp.Z_out), 0);
        idle(); dp.write = 1'b1; dp.writenum = 3'd2; apply();
        read_reg(2, 16, "writeback_r2");

        // Subtract to zero, then to a non-zero result.
        wr_imm(3, 5); wr_imm(4, 5); wr_imm(5, 3);
        ld_a(3); ld_b(4);
        op(1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b1);
        check("sub_zero_out", 32'(dp.datapath_out), 0);
        check("sub_zero_z", 32'(dp.Z_out), 1);
        ld_b(5);
        op(1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b1);
        check("sub_two_out", 32'(dp.datapath_out), 2);
        check("sub_two_z", 32'(dp.Z_out), 0);

        // Shifter variants, and wrap-around on add.
        wr_imm(6, 'h8001); ld_b(6);
        op(1'b1, 1'b0, 2, 0, 0, 1'b1, 1'b1);
        check("lsr", 32'(dp.datapath_out), 'h4000);
        op(1'b1, 1'b0, 3, 0, 0, 1'b1, 1'b1);
        check("asr", 32'(dp.datapath_out), 'hC000);
        op(1'b1, 1'b0, 1, 0, 0, 1'b1, 1'b1);
        check("lsl", 32'(dp.datapath_out), 'h0002);
        wr_imm(7, 'hFFFF); wr_imm(0, 1);
        ld_a(7); ld_b(0);
        op(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
        check("wrap_out", 32'(dp.datapath_out), 0);
        check("wrap_z", 32'(dp.Z_out), 1);

        // Immediate operand, AND, and NOT.
        op(1'b1, 1'b1, 0, 0, 'hFFF3, 1'b1, 1'b1);
        check("imm_out", 32'(dp.datapath_out), 'h0013);
        wr_imm(1, 'h0F0F); wr_imm(2, 'h00FF);
        ld_a(1); ld_b(2);
        op(1'b0, 1'b0, 0, 2, 0, 1'b1, 1'b1);
        check("and_out", 32'(dp.datapath_out), 'h000F);
        op(1'b0, 1'b0, 0, 3, 0, 1'b1, 1'b1);
        check("not_out", 32'(dp.datapath_out), 'hFF00);
        check("not_z", 32'(dp.Z_out), 0);

        // Hold behaviour and reset priority.
        op(1'b0, 1'b0, 0, 4, 0, 1'b0, 1'b0);
        check("hold_c", 32'(dp.datapath_out), 'hFF00);
        check("hold_z", 32'(dp.Z_out), 0);
        op(1'b0, 1'b0, 0, 4, 0, 1'b1, 1'b0);
        check("loadc_only_c", 32'(dp.datapath_out), 0);
        check("loadc_only_z", 32'(dp.Z_out), 0);
        op(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        check("loads_only_c", 32'(dp.datapath_out), 0);
        check("loads_only_z", 32'(dp.Z_out), 0);

        // A read of the register being written returns the old value.
        idle();
        dp.write = 1'b1; dp.vsel = 1'b1; dp.writenum = 3'd4;
        dp.datapath_in = 16'h0AAA; dp.readnum = 3'd4; dp.loada = 1'b1;
        apply();
        op(1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0);
        check("no_bypass", 32'(dp.datapath_out), 5);
        read_reg(4, 'h0AAA, "bypass_later");

        idle();
        reset = 1'b1; dp.write = 1'b1; dp.vsel = 1'b1;
        dp.writenum = 3'd3; dp.datapath_in = 16'h1234;
        apply();
        read_reg(3, 0, "reset_over_write");

        // Random control sequences against the model.
        for (int n = 0; n < 400; n++) begin
            reset          = ($urandom_range(0, 63) == 0);
            dp.datapath_in = DW'($urandom);
            dp.writenum    = 3'($urandom);
            dp.readnum     = 3'($urandom);
            dp.write       = 1'($urandom);
            dp.loada       = 1'($urandom);
            dp.loadb       = 1'($urandom);
            dp.loadc       = 1'($urandom);
            dp.loads       = 1'($urandom);
            dp.asel        = 1'($urandom);
            dp.bsel        = 1'($urandom);
            dp.vsel        = 1'($urandom);
            dp.shift       = 3'($urandom);
            dp.ALUop       = 3'($urandom);
            apply();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Execution datapath for a simple 16-bit RISC machine: an 8-entry register file, A/B operand registers, a 1-bit shifter on the B path, a 4-function ALU, a C result register and a Z status flag.
- The controller or FSM drives all selects and load enables.
- The result in C is visible on datapath_out and can be written back to the register file.

Parameters:
- data_width, 16, width of registers, ALU and data ports (minimum 8).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- datapath_in  input  data_width  external/immediate data (write-back source when vsel=1; immediate source when bsel=1)
- writenum  input  3  register file write index
- readnum  input  3  register file read index (combinational read)
- write  input  1  register file write enable
- loada  input  1  load enable for register A
- loadb  input  1  load enable for register B
- loadc  input  1  load enable for result register C
- loads  input  1  load enable for status flag Z
- asel  input  1  1: ALU A input = 0; 0: A input = register A
- bsel  input  1  1: ALU B input = zero-extended datapath_in[4:0]; 0: B input = shifted register B
- vsel  input  1  1: write-back data = datapath_in; 0: write-back data = datapath_out (C)
- shift  input  3  shifter operation on register B
- ALUop  input  3  ALU operation
- datapath_out  output  data_width  contents of register C
- Z_out  output  1  contents of status flag Z

Behaviour:
- Reset (synchronous): on a rising edge with reset=1, R0..R7, A, B, C and Z clear to 0. Reset has priority over write and all loads. After reset, datapath_out=0 and Z_out=0.
- Register file:
  - Read data = R[readnum], combinational.
  - On a rising edge with write=1, R[writenum] <= (vsel ? datapath_in : datapath_out).
  - Write-back uses the C value present before the edge.
  - If readnum==writenum during a write, read data shows the old value until after the edge (no bypass).
- A/B registers: on a rising edge, A <= read data if loada; B <= read data if loadb. Both may load the same value in one cycle. Otherwise they hold.
- Shifter (on B, combinational):
  - 000: pass-through
  - 001: left shift by 1, LSB=0
  - 010: logical right shift by 1, MSB=0
  - 011: arithmetic right shift by 1, MSB replicated
  - 1xx: pass-through
- ALU operands: Ain = asel ? 0 : A; Bin = bsel ? {zeros, datapath_in[4:0]} : shifter out.
- ALU (combinational, data_width bits, carries/overflow discarded, wrap modulo 2^data_width):
  - 000: Ain+Bin
  - 001: Ain-Bin
  - 010: Ain&Bin
  - 011: ~Bin
  - 1xx: result 0
- C/Z registers:
  - On a rising edge: C <= ALU result if loadc; Z <= (ALU result == 0) if loads. loadc and loads are independent.
  - Z reflects the ALU result of the same cycle, not C.
- Latency:
  - Register read to A/B: 1 edge.
  - A/B to C/Z: 1 edge.
  - C to register file: 1 edge.
  - A full read-operate-writeback sequence is 4 cycles.
- No internal pipelining or bypass. All outputs are register outputs (glitch-free).

Test Plan:
1. Reset: assert reset for 1 edge with all loads/write high -> datapath_out=0, Z_out=0, every register reads 0.
2. MOV/ADD with shift:
   - write R0=7, then R1=2 (vsel=1).
   - readnum=0 with loadb; then readnum=1 with loada.
   - shift=001, ALUop=000, asel=bsel=0, loadc=loads=1.
   - Required: datapath_out=16, Z_out=0.
   - Then vsel=0, writenum=2, write=1 -> R2=16 when read back via A/C.
3. Subtract to zero: A=5, B=5, ALUop=001, loads=1 -> datapath_out=0, Z_out=1. Then A=5, B=3 -> datapath_out=2, Z_out=0.
4. Shifts and wrap:
   - B=0x8001, asel=1, ALUop=000.
   - shift=010 -> 0x4000; shift=011 -> 0xC000; shift=001 -> 0x0002.
   - A=0xFFFF, B=1, add -> 0x0000, Z=1.
5. Immediate/logic:
   - bsel=1, datapath_in=0xFFF3, asel=1, add -> 0x0013.
   - A=0x0F0F, B=0x00FF, AND -> 0x000F.
   - NOT B=0x00FF -> 0xFF00.
6. Hold/priority:
   - loadc=0 with a changed ALUop -> C unchanged.
   - loads=0 -> Z unchanged.
   - reset=1 with write=1 -> register target stays 0.
